// File: rtl/ifetcher_pkg.sv
// Shared fetch-stage types: opcodes, FSM states, queue entry layout and
// immediate extraction helpers.
package ifetcher_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] LUIOP   = 7'b0110111;
   localparam logic [6:0] AUIPCOP = 7'b0010111;
   localparam logic [6:0] JALOP   = 7'b1101111;
   localparam logic [6:0] JALROP  = 7'b1100111;
   localparam logic [6:0] BROP    = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_HALT,
      ST_DROP
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] ins;
      logic            jump_flag;
      logic [XLEN-1:0] jump_pc;
   } q_entry_t;

   localparam int unsigned ENTRY_W = $bits(q_entry_t);

   function automatic logic [XLEN-1:0] imm_j(input logic [XLEN-1:0] ins);
      return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
   endfunction

   function automatic logic [XLEN-1:0] imm_b(input logic [XLEN-1:0] ins);
      return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/ifetcher_if.sv
// Instruction-memory request bus between the fetch stage (master) and the
// memory controller (slave).
interface ifetcher_if;
   import ifetcher_pkg::*;

   logic            MC_req;
   logic [XLEN-1:0] MC_addr;
   logic            MC_done;
   logic [XLEN-1:0] MC_data;

   modport master (output MC_req, output MC_addr, input MC_done, input MC_data);
   modport slave  (input MC_req, input MC_addr, output MC_done, output MC_data);
endinterface

// File: rtl/ifetcher_queue.sv
// Circular in-order FIFO with flush; pointers carry an extra wrap bit so
// full and empty are distinguishable without a counter.
module ifetcher_queue #(
   parameter int unsigned DEPTH_BITS = 3,
   parameter int unsigned WIDTH      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_c_o,
   output logic             full_c_o,
   output logic             empty_c_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_BITS;
   localparam int unsigned PTR_W = DEPTH_BITS + 1;

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty_c_o = (head_q == tail_q);
   assign full_c_o  = (head_q[DEPTH_BITS-1:0] == tail_q[DEPTH_BITS-1:0]) &&
                      (head_q[DEPTH_BITS] != tail_q[DEPTH_BITS]);
   assign head_c_o  = mem_q[head_q[DEPTH_BITS-1:0]];

   assign do_push = en_i && !flush_i && push_i && !full_c_o;
   assign do_pop  = en_i && !flush_i && pop_i && !empty_c_o;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      if (en_i && flush_i) begin
         head_d = '0;
         tail_d = '0;
      end else begin
         if (do_push) tail_d = tail_q + PTR_W'(1);
         if (do_pop)  head_d = head_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Payload storage needs no reset: reads are qualified by empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[tail_q[DEPTH_BITS-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/ifetcher.sv
// Fetch stage: one outstanding memory request, static JAL follow, 2-bit BHT
// for conditional branches, in-order instruction queue towards issue.
module ifetcher
   import ifetcher_pkg::*;
#(
   parameter int unsigned     QUEUE_BITS = 3,
   parameter int unsigned     BHT_BITS   = 6,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            stall,
   output logic            IF_ins_sgn,
   output logic [XLEN-1:0] IF_ins,
   output logic            IF_jump_flag,
   output logic [XLEN-1:0] IF_jump_pc,
   ifetcher_if.master      mc,
   input  logic            ROB_clear,
   input  logic [XLEN-1:0] ROB_newpc,
   input  logic            ROB_br_sgn,
   input  logic [XLEN-1:0] ROB_br_pc,
   input  logic            ROB_br_taken
);

   localparam int unsigned BHT_ENTRIES = 1 << BHT_BITS;

   fetch_state_e     state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic             mc_req_q, mc_req_d;
   logic [XLEN-1:0]  mc_addr_q, mc_addr_d;
   logic [1:0]       bht_q [BHT_ENTRIES];

   logic [BHT_BITS-1:0] lookup_idx, train_idx;
   logic                predict_taken;
   q_entry_t            dec_entry, q_head;
   logic [XLEN-1:0]     dec_next_pc, pc_plus4;
   logic                dec_halt;
   logic                q_push, q_pop, q_full, q_empty;
   logic                unused_br_pc;

   assign unused_br_pc  = ^{ROB_br_pc[XLEN-1:BHT_BITS+2], ROB_br_pc[1:0]};
   assign lookup_idx    = pc_q[BHT_BITS+1:2];
   assign train_idx     = ROB_br_pc[BHT_BITS+1:2];
   assign predict_taken = bht_q[lookup_idx][1];
   assign pc_plus4      = pc_q + 32'd4;

   // Decode the returning word: queue payload and predicted next fetch pc.
   always_comb begin
      dec_entry.ins       = mc.MC_data;
      dec_entry.jump_flag = 1'b0;
      dec_entry.jump_pc   = pc_plus4;
      dec_next_pc         = pc_plus4;
      dec_halt            = 1'b0;
      case (mc.MC_data[6:0])
         AUIPCOP: dec_entry.jump_pc = pc_q;
         JALOP:   dec_next_pc = pc_q + imm_j(mc.MC_data);
         JALROP:  dec_halt = 1'b1;
         BROP: begin
            if (predict_taken) begin
               dec_entry.jump_flag = 1'b1;
               dec_next_pc         = pc_q + imm_b(mc.MC_data);
            end else begin
               dec_entry.jump_pc   = pc_q + imm_b(mc.MC_data);
            end
         end
         LUIOP:   dec_next_pc = pc_plus4;
         default: dec_next_pc = pc_plus4;
      endcase
   end

   // Next-state logic; a flush overrides everything else.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      mc_req_d  = mc_req_q;
      mc_addr_d = mc_addr_q;
      q_push    = 1'b0;
      if (ROB_clear) begin
         pc_d = ROB_newpc;
         if (state_q == ST_FETCH || state_q == ST_DROP) begin
            if (mc.MC_done) begin
               mc_req_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_DROP;
            end
         end else begin
            state_d = ST_IDLE;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!q_full) begin
                  mc_req_d  = 1'b1;
                  mc_addr_d = pc_q;
                  state_d   = ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (mc.MC_done) begin
                  mc_req_d = 1'b0;
                  q_push   = 1'b1;
                  pc_d     = dec_next_pc;
                  state_d  = dec_halt ? ST_HALT : ST_IDLE;
               end
            end
            ST_HALT: state_d = ST_HALT;
            ST_DROP: begin
               if (mc.MC_done) begin
                  mc_req_d = 1'b0;
                  state_d  = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         mc_req_q  <= 1'b0;
         mc_addr_q <= '0;
      end else if (rdy) begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         mc_req_q  <= mc_req_d;
         mc_addr_q <= mc_addr_d;
      end
   end

   // Branch history: saturating 2-bit counters trained at commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      end else if (rdy && ROB_br_sgn) begin
         if (ROB_br_taken) begin
            if (bht_q[train_idx] != 2'b11) bht_q[train_idx] <= bht_q[train_idx] + 2'd1;
         end else begin
            if (bht_q[train_idx] != 2'b00) bht_q[train_idx] <= bht_q[train_idx] - 2'd1;
         end
      end
   end

   assign q_pop = !q_empty && !stall;

   ifetcher_queue #(
      .DEPTH_BITS (QUEUE_BITS),
      .WIDTH      (ENTRY_W)
   ) u_queue (
      .clk         (clk),
      .rst_n       (rst),
      .en_i        (rdy),
      .flush_i     (ROB_clear),
      .push_i      (q_push),
      .push_data_i (dec_entry),
      .pop_i       (q_pop),
      .head_c_o    (q_head),
      .full_c_o    (q_full),
      .empty_c_o   (q_empty)
   );

   assign mc.MC_req    = mc_req_q;
   assign mc.MC_addr   = mc_addr_q;
   assign IF_ins_sgn   = !q_empty;
   assign IF_ins       = q_empty ? '0 : q_head.ins;
   assign IF_jump_flag = q_empty ? 1'b0 : q_head.jump_flag;
   assign IF_jump_pc   = q_empty ? '0 : q_head.jump_pc;

endmodule

// File: tb/tb_ifetcher.sv
// Bench for ifetcher: memory responder plus a fetch-stream reference model
// (predicted pc sequence, expected queue contents, BHT counters).
module tb_ifetcher;
   import ifetcher_pkg::*;

   logic        clk = 1'b0;
   logic        rst, rdy, stall;
   logic        IF_ins_sgn, IF_jump_flag;
   logic [31:0] IF_ins, IF_jump_pc;
   logic        ROB_clear, ROB_br_sgn, ROB_br_taken;
   logic [31:0] ROB_newpc, ROB_br_pc;

   ifetcher_if mc();

   ifetcher dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .stall        (stall),
      .IF_ins_sgn   (IF_ins_sgn),
      .IF_ins       (IF_ins),
      .IF_jump_flag (IF_jump_flag),
      .IF_jump_pc   (IF_jump_pc),
      .mc           (mc),
      .ROB_clear    (ROB_clear),
      .ROB_newpc    (ROB_newpc),
      .ROB_br_sgn   (ROB_br_sgn),
      .ROB_br_pc    (ROB_br_pc),
      .ROB_br_taken (ROB_br_taken)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      logic        flag;
      logic [31:0] jpc;
   } exp_t;

   int          checks   = 0;
   int          failures = 0;
   exp_t        exp_q[$];
   exp_t        pop_log[$];
   logic [31:0] req_log[$];
   logic [31:0] model_pc;
   bit          model_halted;
   int          bht[64];
   logic [31:0] mem [bit [31:0]];
   bit          rand_mode;
   bit          mem_busy, mem_drop;
   int          mem_cnt, lat_min, lat_max;
   logic [31:0] mem_addr;
   bit          stall_n, rdy_n, clr_n, br_n, brt_n;
   logic [31:0] newpc_n, brpc_n;

   localparam logic [31:0] W_ADDI = 32'h00100093;
   localparam logic [31:0] W_JAL  = 32'h010000EF;
   localparam logic [31:0] W_BEQ  = 32'h00000463;
   localparam logic [31:0] W_JALR = 32'h000080E7;
   localparam logic [31:0] W_MARK = 32'h00200113;

   function automatic logic [31:0] gen_word();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 11))
         0, 1, 2, 3: return {r[31:7], 7'h13};
         4:          return {r[31:7], 7'h37};
         5:          return {r[31:7], 7'h17};
         6, 7: begin r[21] = 1'b0; return {r[31:7], 7'h6F}; end
         8, 9, 10: begin r[8] = 1'b0; return {r[31:7], 7'h63}; end
         default:    return {r[31:7], 7'h67};
      endcase
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      if (mem.exists(a)) return mem[a];
      w = rand_mode ? gen_word() : 32'h00000013;
      mem[a] = w;
      return w;
   endfunction

   function automatic int j_off(input logic [31:0] w);
      return (w[31] ? -1048576 : 0) + (int'(w[19:12]) << 12) + (int'(w[20]) << 11) +
             (int'(w[30:21]) << 1);
   endfunction

   function automatic int b_off(input logic [31:0] w);
      return (w[31] ? -4096 : 0) + (int'(w[7]) << 11) + (int'(w[30:25]) << 5) +
             (int'(w[11:8]) << 1);
   endfunction

   // One fetched word through the prediction rules.
   function automatic void model_fetch(input logic [31:0] w);
      exp_t        e;
      logic [31:0] pc, nxt;
      int          idx;
      pc    = model_pc;
      idx   = int'((pc >> 2) & 32'd63);
      e.ins = w;
      e.flag = 1'b0;
      e.jpc = pc + 32'd4;
      nxt   = pc + 32'd4;
      case (w[6:0])
         7'h17: e.jpc = pc;
         7'h6F: nxt = pc + 32'(j_off(w));
         7'h67: model_halted = 1'b1;
         7'h63: begin
            if (bht[idx] >= 2) begin
               e.flag = 1'b1;
               nxt    = pc + 32'(b_off(w));
            end else begin
               e.jpc  = pc + 32'(b_off(w));
            end
         end
         default: ;
      endcase
      exp_q.push_back(e);
      model_pc = nxt;
   endfunction

   function automatic void model_train(input logic [31:0] pc, input bit taken);
      int idx;
      idx = int'((pc >> 2) & 32'd63);
      if (taken && bht[idx] < 3) bht[idx]++;
      if (!taken && bht[idx] > 0) bht[idx]--;
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      model_pc     = 32'h0;
      model_halted = 1'b0;
      for (int i = 0; i < 64; i++) bht[i] = 1;
      mem_busy = 1'b0;
      mem_drop = 1'b0;
      mem_cnt  = 0;
   endfunction

   // Advance one cycle: drive inputs, check the head and any new request,
   // run the memory responder and keep the model in step.
   task automatic step();
      exp_t        e, got;
      logic [31:0] w;
      @(negedge clk);
      rdy          = rdy_n;
      stall        = stall_n;
      ROB_clear    = clr_n & rdy_n;
      ROB_newpc    = newpc_n;
      ROB_br_sgn   = br_n & rdy_n;
      ROB_br_pc    = brpc_n;
      ROB_br_taken = brt_n;

      checks++;
      if (IF_ins_sgn !== (exp_q.size() != 0)) begin
         failures++;
         $display("FAIL head_valid: got %b want %b", IF_ins_sgn, exp_q.size() != 0);
      end
      if (rdy && !ROB_clear && IF_ins_sgn && !stall && exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (IF_ins !== e.ins || IF_jump_flag !== e.flag || IF_jump_pc !== e.jpc) begin
            failures++;
            $display("FAIL pop: got ins=%h flag=%b jpc=%h want ins=%h flag=%b jpc=%h",
                     IF_ins, IF_jump_flag, IF_jump_pc, e.ins, e.flag, e.jpc);
         end
         got.ins  = IF_ins;
         got.flag = IF_jump_flag;
         got.jpc  = IF_jump_pc;
         pop_log.push_back(got);
      end
      if (!mem_busy && mc.MC_req === 1'b1) begin
         checks++;
         if (mc.MC_addr !== model_pc || model_halted || exp_q.size() >= 8) begin
            failures++;
            $display("FAIL request: got addr=%h want addr=%h (halted=%0b queued=%0d)",
                     mc.MC_addr, model_pc, model_halted, exp_q.size());
         end
         req_log.push_back(mc.MC_addr);
         mem_busy = 1'b1;
         mem_drop = 1'b0;
         mem_addr = mc.MC_addr;
         mem_cnt  = $urandom_range(lat_min, lat_max);
      end
      mc.MC_done = 1'b0;
      mc.MC_data = $urandom;
      if (mem_busy && rdy) begin
         if (mem_cnt == 0) begin
            w          = mem_word(mem_addr);
            mc.MC_done = 1'b1;
            mc.MC_data = w;
            mem_busy   = 1'b0;
            if (!mem_drop && !ROB_clear) model_fetch(w);
         end else begin
            mem_cnt--;
         end
      end
      if (ROB_clear) begin
         exp_q.delete();
         model_pc     = ROB_newpc;
         model_halted = 1'b0;
         if (mem_busy) mem_drop = 1'b1;
      end
      if (ROB_br_sgn) model_train(ROB_br_pc, ROB_br_taken);
   endtask

   task automatic clear_to(input logic [31:0] pc);
      clr_n   = 1'b1;
      newpc_n = pc;
      step();
      clr_n   = 1'b0;
      req_log.delete();
      pop_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rdy = 1'b1; stall = 1'b0; ROB_clear = 1'b0; ROB_br_sgn = 1'b0;
      ROB_newpc = '0; ROB_br_pc = '0; ROB_br_taken = 1'b0;
      mc.MC_done = 1'b0; mc.MC_data = '0;
      stall_n = 0; rdy_n = 1; clr_n = 0; br_n = 0; brt_n = 0; newpc_n = '0; brpc_n = '0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({mc.MC_req, IF_ins_sgn, IF_jump_flag} !== 3'b000 || IF_ins !== 32'h0 || IF_jump_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: got req=%b sgn=%b flag=%b ins=%h jpc=%h want all zero",
                  mc.MC_req, IF_ins_sgn, IF_jump_flag, IF_ins, IF_jump_pc);
      end
      rst = 1'b1;
      req_log.delete();
      pop_log.delete();
   endtask

   task automatic test_basic();
      lat_min = 3; lat_max = 3; rand_mode = 1'b0;
      mem.delete();
      mem[32'h0] = W_ADDI; mem[32'h8] = W_JAL; mem[32'h20] = W_BEQ;
      for (int i = 0; i < 300 && (req_log.size() < 7 || pop_log.size() < 6); i++) step();
      checks++;
      if (req_log.size() < 7 || pop_log.size() < 6) begin
         failures++;
         $display("FAIL basic_timeout: got reqs=%0d pops=%0d want 7/6", req_log.size(), pop_log.size());
      end else begin
         checks++;
         if (req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || pop_log[0].ins !== W_ADDI || pop_log[0].jpc !== 32'h4) begin
            failures++;
            $display("FAIL basic_addi: got a0=%h a1=%h ins=%h jpc=%h want 0/4/%h/4",
                     req_log[0], req_log[1], pop_log[0].ins, pop_log[0].jpc, W_ADDI);
         end
         checks++;
         if (pop_log[2].ins !== W_JAL || pop_log[2].jpc !== 32'hC || req_log[3] !== 32'h18) begin
            failures++;
            $display("FAIL basic_jal: got ins=%h jpc=%h next=%h want %h/c/18",
                     pop_log[2].ins, pop_log[2].jpc, req_log[3], W_JAL);
         end
         checks++;
         if (pop_log[5].ins !== W_BEQ || pop_log[5].flag !== 1'b0 || pop_log[5].jpc !== 32'h28 || req_log[6] !== 32'h24) begin
            failures++;
            $display("FAIL basic_beq_nt: got flag=%b jpc=%h next=%h want 0/28/24",
                     pop_log[5].flag, pop_log[5].jpc, req_log[6]);
         end
      end
   endtask

   task automatic test_bht_train();
      br_n = 1'b1; brpc_n = 32'h20; brt_n = 1'b1;
      step(); step();
      br_n = 1'b0;
      clear_to(32'h20);
      for (int i = 0; i < 100 && (req_log.size() < 2 || pop_log.size() < 1); i++) step();
      checks++;
      if (req_log.size() < 2 || pop_log.size() < 1) begin
         failures++;
         $display("FAIL bht_timeout: got reqs=%0d pops=%0d want 2/1", req_log.size(), pop_log.size());
      end else if (req_log[0] !== 32'h20 || pop_log[0].flag !== 1'b1 || pop_log[0].jpc !== 32'h24 || req_log[1] !== 32'h28) begin
         failures++;
         $display("FAIL bht_taken: got a0=%h flag=%b jpc=%h next=%h want 20/1/24/28",
                  req_log[0], pop_log[0].flag, pop_log[0].jpc, req_log[1]);
      end
   endtask

   task automatic test_full();
      stall_n = 1'b1;
      clear_to(32'h200);
      for (int i = 0; i < 120; i++) step();
      checks++;
      if (req_log.size() != 8 || pop_log.size() != 0 || mc.MC_req !== 1'b0 || IF_ins_sgn !== 1'b1) begin
         failures++;
         $display("FAIL full_hold: got reqs=%0d pops=%0d req=%b sgn=%b want 8/0/0/1",
                  req_log.size(), pop_log.size(), mc.MC_req, IF_ins_sgn);
      end
      stall_n = 1'b0;
      repeat (4) step();
      checks++;
      if (pop_log.size() != 4) begin
         failures++;
         $display("FAIL full_drain_rate: got pops=%0d want 4", pop_log.size());
      end
      for (int i = 0; i < 30 && req_log.size() < 9; i++) step();
      checks++;
      if (req_log.size() < 9 || req_log[req_log.size()-1] !== 32'h220) begin
         failures++;
         $display("FAIL full_resume: got reqs=%0d want ninth request at 220", req_log.size());
      end
   endtask

   task automatic test_flush();
      mem[32'h100] = W_MARK;
      mem[32'h108] = W_JALR;
      for (int i = 0; i < 20 && !mem_busy; i++) step();
      clear_to(32'h100);
      @(posedge clk); #1;
      checks++;
      if (IF_ins_sgn !== 1'b0) begin
         failures++;
         $display("FAIL flush_empty: got sgn=%b want 0", IF_ins_sgn);
      end
      for (int i = 0; i < 60 && (req_log.size() < 1 || pop_log.size() < 1); i++) step();
      checks++;
      if (req_log.size() < 1 || pop_log.size() < 1) begin
         failures++;
         $display("FAIL flush_timeout: got reqs=%0d pops=%0d want 1/1", req_log.size(), pop_log.size());
      end else if (req_log[0] !== 32'h100 || pop_log[0].ins !== W_MARK) begin
         failures++;
         $display("FAIL flush_redirect: got addr=%h ins=%h want 100/%h", req_log[0], pop_log[0].ins, W_MARK);
      end
   endtask

   task automatic test_jalr();
      for (int i = 0; i < 60; i++) step();
      checks++;
      if (req_log.size() != 3 || mc.MC_req !== 1'b0 || pop_log.size() < 1 ||
          pop_log[pop_log.size()-1].ins !== W_JALR || pop_log[pop_log.size()-1].jpc !== 32'h10C) begin
         failures++;
         $display("FAIL jalr_halt: got reqs=%0d req=%b pops=%0d want 3 reqs, no req, last pop jalr jpc 10c",
                  req_log.size(), mc.MC_req, pop_log.size());
      end
      clear_to(32'h40);
      for (int i = 0; i < 20 && req_log.size() < 1; i++) step();
      checks++;
      if (req_log.size() < 1 || req_log[0] !== 32'h40) begin
         failures++;
         $display("FAIL jalr_resume: got reqs=%0d want first request at 40", req_log.size());
      end
   endtask

   task automatic test_random();
      rand_mode = 1'b1;
      lat_min = 0; lat_max = 3;
      mem.delete();
      clear_to(32'h1000);
      for (int i = 0; i < 3000; i++) begin
         stall_n = ($urandom_range(0, 3) == 0);
         rdy_n   = ($urandom_range(0, 9) != 0);
         clr_n   = model_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
         newpc_n = $urandom & 32'hFFFF_FFFC;
         br_n    = ($urandom_range(0, 4) == 0);
         brpc_n  = $urandom;
         brt_n   = $urandom_range(0, 1);
         step();
      end
      clr_n = 1'b0; br_n = 1'b0; rdy_n = 1'b1; stall_n = 1'b0;
      repeat (5) step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bht_train();
      test_full();
      test_flush();
      test_jalr();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
